divisible_n_tx: RTL
===================

Name: divisible_n_tx

Overview:
- Serial transmitter feeding the divisible-by-N bit-stream checker.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per cycle.
- After the data bits it appends CHK check bits, chosen so the whole frame's binary value is divisible by MOD.
- A downstream serial mod-N checker therefore reads residue 0 on the frame's last bit.

Parameters:
- WIDTH, 8, data word width in bits; must be >= 1.
- MOD, 5, divisor N; must be >= 2.
- CHK, $clog2(MOD), localparam: number of appended check bits.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to transmit.
- out  output  1  serial bit; MSB first.
- out_valid  output  1  out carries a frame bit this cycle.
- out_last  output  1  final bit of the frame (last check bit).

Behaviour:
- Reset:
  - Applied on any clk edge with rst=1, including mid-frame.
  - Next cycle: out=0, out_valid=0, out_last=0, in_ready=1, state IDLE, residue=0.
  - A partial frame is abandoned; nothing resumes after reset.
- Handshake:
  - A word is accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready=1 in IDLE, and in the cycle where out_last=1.
  - in_ready=0 for all other cycles.
- States:
  - IDLE -> DATA on accept.
  - DATA -> CHECK after WIDTH data bits.
  - CHECK -> IDLE after CHK bits, if no word is accepted in the out_last cycle.
  - CHECK -> DATA if a word is accepted in the out_last cycle. Frames then run back-to-back with no gap cycle.
- Latency and framing:
  - The cycle after accept has out_valid=1 and out=in_data[WIDTH-1].
  - Data bits are in_data[WIDTH-1] down to in_data[0] on consecutive cycles.
  - The CHK check bits follow, MSB first.
  - out_valid stays 1 for exactly WIDTH+CHK contiguous cycles per frame.
  - out_last=1 only on the final check bit.
- Data capture: in_data is registered on accept; later changes to in_data do not affect the frame in flight.
- Residue:
  - Running residue r is updated per data bit b: r <= (2r + b) mod MOD.
  - Width is ceil(log2(MOD)) bits, plus one guard bit for the doubling.
  - The reduction is a single conditional subtract, since 2r+b < 2*MOD.
  - r resets to 0 at every frame start.
- Check value:
  - Let D be the data word.
  - t = (D * 2^CHK) mod MOD, obtainable as r doubled CHK times with a mod after each step.
  - c = (MOD - t) mod MOD.
  - c < MOD <= 2^CHK, so it always fits in CHK bits.
  - Invariant: (D * 2^CHK + c) mod MOD == 0.
  - c must be stable before the first check bit; no bubble is inserted between data and check bits.
- Special case: if MOD is a power of two, c == 0 for every D.
- Idle outputs: while out_valid=0, out=0 and out_last=0.

Test Plan:
1. WIDTH=8, MOD=5, in_data=0x0D accepted at cycle 0:
   - cycles 1-11 out = 0,0,0,0,1,1,0,1, 0,0,1 (frame value 105 = 21*5).
   - out_last=1 only at cycle 11.
   - in_ready=0 during cycles 1-10.
2. MOD=5, in_data=0x01 -> check bits 010 (frame value 10). Then in_data=0xFF -> check bits 000 (frame value 2040).
3. MOD=7, in_data=0x0D -> check bits 001 (frame value 105 = 15*7). Then MOD=8, any in_data -> check bits 000.
4. Back-to-back: in_valid held high with words 0x0D then 0x01 (MOD=5):
   - second word is accepted in the out_last cycle.
   - out_valid stays high for 22 consecutive cycles.
   - second frame's check bits are 010.
5. rst=1 asserted at the 4th data bit of a frame:
   - next cycle out_valid=0 and in_ready=1.
   - a new word 0x00 transmits 11 zero bits with correct out_last.
6. Randomized D with MOD in {3,5,7,11}: a reference serial mod-MOD checker on out/out_valid must reach residue 0 at every out_last.

Source files
------------

// File: rtl/divisible_n_tx.sv
// Serial transmitter: shifts a word out MSB-first, then appends check bits so the frame value is divisible by MOD.
// First bit one cycle after accept; in_ready only in IDLE or on the last check bit, so frames can run back-to-back.
module divisible_n_tx #(
  parameter int WIDTH = 8,
  parameter int MOD   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CHK = $clog2(MOD);
  localparam int RW  = CHK + 1;
  localparam int CW  = $clog2(WIDTH + CHK + 1);
  localparam logic [RW-1:0] MOD_R = RW'(MOD);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CHK-1:0]   chk_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    res_q;
  logic             out_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic             accept;
  logic [RW-1:0]    res_d;
  logic [CHK-1:0]   chk_d;

  // 2r+b < 2*MOD, so one conditional subtract fully reduces it.
  function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] r, input logic b);
    logic [RW-1:0] s;
    s = (r << 1) | {{(RW-1){1'b0}}, b};
    if (s >= MOD_R) s = s - MOD_R;
    return s;
  endfunction

  function automatic logic [CHK-1:0] check_of(input logic [RW-1:0] r);
    logic [RW-1:0] t;
    t = r;
    for (int i = 0; i < CHK; i++) t = mod_step(t, 1'b0);
    return (t == '0) ? '0 : CHK'(MOD_R - t);
  endfunction

  always_comb begin
    accept = in_valid && in_ready;
    // Residue including the bit currently on the wire; on the last data
    // bit this yields the check value with no bubble before the check bits.
    res_d  = mod_step(res_q, out_q);
    chk_d  = check_of(res_d);
  end

  assign in_ready  = (state_q == IDLE) || out_last_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      state_q     <= DATA;
      data_q      <= in_data << 1;
      cnt_q       <= CW'(WIDTH - 1);
      res_q       <= '0;
      out_q       <= in_data[WIDTH-1];
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
        DATA: begin
          res_q <= res_d;
          if (cnt_q == '0) begin
            state_q    <= CHECK;
            out_q      <= chk_d[CHK-1];
            chk_q      <= chk_d << 1;
            cnt_q      <= CW'(CHK - 1);
            out_last_q <= (CHK == 1) ? 1'b1 : 1'b0;
          end else begin
            out_q  <= data_q[WIDTH-1];
            data_q <= data_q << 1;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        CHECK: begin
          if (cnt_q == '0) begin
            state_q     <= IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            out_q      <= chk_q[CHK-1];
            chk_q      <= chk_q << 1;
            cnt_q      <= cnt_q - 1'b1;
            out_last_q <= (cnt_q == CW'(1)) ? 1'b1 : 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
